disparity_select: RTL

- Downstream consumer of the window-sum/correlation stage.
- Accumulates per-candidate partial match scores (one per candidate horizontal offset per row, 16 rows per frame) into a bank of NUM_CAND registers.
- At frame end, scans the bank for the minimum score and presents the winning offset index, its score and a confidence flag to the output stage through a valid/ready handshake.

---
 rtl/disparity_select.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/disparity_select.sv
// Accumulates per-candidate match scores over a frame, then scans for the minimum-score offset.
// Latency: result_valid rises NUM_CAND+1 cycles after the edge that samples frame_end.
// Backpressure: none on the input side; the result is held in OUT until result_ready is high.
module disparity_select #(
    parameter int NUM_CAND = 64,
    parameter int IDX_W    = 6,
    parameter int PART_W   = 10,
    parameter int ACC_W    = 14,
    parameter int MARGIN   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              acc_valid,
    input  logic [IDX_W-1:0]  acc_idx,
    input  logic [PART_W-1:0] acc_data,
    input  logic              frame_end,
    input  logic              result_ready,
    output logic              busy,
    output logic              result_valid,
    output logic [IDX_W-1:0]  best_idx,
    output logic [ACC_W-1:0]  best_score,
    output logic              confident,
    output logic              dropped
);

    localparam int BW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int PW = BW + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, OUT} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] bank [NUM_CAND];
    logic [PW-1:0]    ptr;
    logic [ACC_W-1:0] run_best, run_second;
    logic [IDX_W-1:0] run_idx;
    logic             in_range, scan_last;
    logic [BW-1:0]    wr_sel;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] cur, wr_val, gap;
    logic             bank_wr, drop_set, scan_start;

    // Index range check collapses to constant true when the index width covers the bank exactly.
    generate
        if (NUM_CAND >= (1 << IDX_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (acc_idx < IDX_W'(NUM_CAND));
        end
    endgenerate

    assign wr_sel    = BW'(acc_idx);
    assign sum       = {1'b0, bank[wr_sel]} + (ACC_W+1)'(acc_data);
    // A frame_start write lands on a freshly cleared entry, so it stores the raw sample.
    assign wr_val    = frame_start ? ACC_W'(acc_data)
                                   : (sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0]);
    assign cur       = bank[ptr[BW-1:0]];
    assign scan_last = (ptr == PW'(NUM_CAND));
    assign gap       = run_second - run_best;
    assign busy      = (state == SCAN) || (state == OUT);
    assign result_valid = (state == OUT);

    // Next-state and per-cycle control; frame_start overrides every state.
    always_comb begin
        state_nxt  = state;
        bank_wr    = 1'b0;
        drop_set   = 1'b0;
        scan_start = 1'b0;
        if (frame_start) begin
            state_nxt = ACCUM;
            bank_wr   = acc_valid && in_range;
            drop_set  = acc_valid && !in_range;
        end else begin
            case (state)
                IDLE: ;
                ACCUM: begin
                    bank_wr  = acc_valid && in_range;
                    drop_set = acc_valid && !in_range;
                    if (frame_end) begin
                        state_nxt  = SCAN;
                        scan_start = 1'b1;
                    end
                end
                SCAN: begin
                    drop_set = acc_valid;
                    if (scan_last) state_nxt = OUT;
                end
                OUT: begin
                    drop_set = acc_valid;
                    if (result_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Score bank: cleared on frame_start, then saturating accumulate of in-range samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) bank[i] <= '0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_CAND; i++) bank[i] <= '0;
            end
            if (bank_wr) bank[wr_sel] <= wr_val;
        end
    end

    // Sticky drop flag, restarted by each frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           dropped <= 1'b0;
        else if (frame_start) dropped <= drop_set;
        else if (drop_set)    dropped <= 1'b1;
    end

    // Sequential min/second-min scan; strict compare keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            run_best   <= '0;
            run_second <= '0;
            run_idx    <= '0;
        end else if (scan_start) begin
            ptr        <= '0;
            run_best   <= '1;
            run_second <= '1;
            run_idx    <= '0;
        end else if (state == SCAN && !scan_last && !frame_start) begin
            if (cur < run_best) begin
                run_second <= run_best;
                run_best   <= cur;
                run_idx    <= IDX_W'(ptr);
            end else if (cur < run_second) begin
                run_second <= cur;
            end
            ptr <= ptr + 1'b1;
        end
    end

    // Result registers, loaded once in the extra cycle after the last entry is compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_idx   <= '0;
            best_score <= '0;
            confident  <= 1'b0;
        end else if (state == SCAN && scan_last && !frame_start) begin
            best_idx   <= run_idx;
            best_score <= run_best;
            confident  <= (gap >= ACC_W'(MARGIN));
        end
    end

endmodule
